// File: rtl/opl_wrq_pkg.sv
// opl_wrq_pkg: shared entry type and pacing counter width for the OPL write queue
package opl_wrq_pkg;
  localparam int WRQ_ABITS = 2;
  localparam int WRQ_GAPW = 8;
  typedef struct packed {
    logic [WRQ_ABITS-1:0] addr;
    logic [7:0] data;
  } opl_wrq_entry_t;
endpackage

// File: rtl/opl_wr_queue_if.sv
// opl_wr_queue_if: push side, status and show-ahead head handshake of the write queue
interface opl_wr_queue_if #(parameter int DEPTH = 1024, parameter int ABITS = 2);
  localparam int LW = $clog2(DEPTH) + 1;
  logic wr;
  logic [ABITS-1:0] addr;
  logic [7:0] din;
  logic full;
  logic [LW-1:0] level;
  logic overflow;
  logic ovf_clr;
  logic [ABITS-1:0] q_addr;
  logic [7:0] q_data;
  logic q_valid;
  logic q_ready;
  modport master (output wr, addr, din, ovf_clr, q_ready, input full, level, overflow, q_addr, q_data, q_valid);
  modport slave (input wr, addr, din, ovf_clr, q_ready, output full, level, overflow, q_addr, q_data, q_valid);
endinterface

// File: rtl/opl_wrq_ram.sv
// opl_wrq_ram: simple dual-port RAM, sync write, registered read, read-old-data on collision
module opl_wrq_ram #(
  parameter int DEPTH = 1024,
  parameter int W = 10
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/opl_wr_queue.sv
// opl_wr_queue: FWFT register-write queue with level, sticky overflow and optional pacing (OPL_WRQ_PACE_EN)
module opl_wr_queue import opl_wrq_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int ABITS = 2,
  parameter int GAP_ADDR = 32,
  parameter int GAP_DATA = 96
) (
  input logic clk,
  input logic reset,
  opl_wr_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int W = ABITS + 8;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d, pend;
  logic ovf_q, ovf_d, r_v_q, r_v_d, h_v_q, h_v_d;
  logic [W-1:0] head_q, head_d, rdata;
  logic push, pop, load, rd_en;
  logic [WRQ_GAPW-1:0] cnt;
  opl_wrq_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
    .clk(clk), .we_i(push), .waddr_i(wptr_q), .wdata_i({bus.addr, bus.din}),
    .re_i(rd_en), .raddr_i(rptr_q), .rdata_o(rdata)
  );
  // r_v tracks the RAM read register as a prefetch stage feeding the head
  always_comb begin
    push = bus.wr && level_q != LW'(DEPTH);
    pop = bus.q_valid && bus.q_ready;
    load = r_v_q && (!h_v_q || pop);
    pend = level_q - LW'(r_v_q) - LW'(h_v_q);
    rd_en = pend != '0 && (!r_v_q || load);
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = rd_en ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q + LW'(push) - LW'(pop);
    ovf_d = bus.ovf_clr ? 1'b0 : (ovf_q || (bus.wr && !push));
    r_v_d = rd_en || (r_v_q && !load);
    h_v_d = load || (h_v_q && !pop);
    head_d = load ? rdata : head_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      r_v_q <= 1'b0;
      h_v_q <= 1'b0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      r_v_q <= r_v_d;
      h_v_q <= h_v_d;
      head_q <= head_d;
    end
  end
`ifdef OPL_WRQ_PACE_EN
  logic [WRQ_GAPW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = pop ? (head_q[8] ? WRQ_GAPW'(GAP_DATA) : WRQ_GAPW'(GAP_ADDR))
                          : (cnt_q != '0 ? cnt_q - WRQ_GAPW'(1) : cnt_q);
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign cnt = cnt_q;
`else
  logic unused_gap;
  assign unused_gap = (GAP_ADDR + GAP_DATA) != 0;
  assign cnt = '0;
`endif
  assign bus.q_valid = h_v_q && cnt == '0;
  assign bus.full = level_q == LW'(DEPTH);
  assign bus.level = level_q;
  assign bus.overflow = ovf_q;
  assign bus.q_addr = head_q[W-1:8];
  assign bus.q_data = head_q[7:0];
endmodule
